alu4_share_ctrl: RTL
====================

// Module: alu4_share_ctrl
// PURPOSE
//  Controller that time-shares one 4-bit ALU datapath between two requesters.
//  Arbitrates round-robin, registers the operands and opcode, and drives them onto the ALU for ALU_LAT cycles.
//  Captures the result and flags, then returns them to the winning requester over a valid/ready response channel.
//  Sits between requester logic (ports 0/1) and the alu4 datapath built from the 4-bit gate primitives.
// PARAMETERS
//  WIDTH    4  operand/result width; fixed at 4 for alu4
//  OP_W     3  opcode width forwarded unchanged to the ALU
//  ALU_LAT  1  cycles operands are held on the ALU before result capture; legal range 1..4
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high reset
//  req0_valid   in   1        requester 0 has an operation
//  req0_ready   out  1        requester 0 operation accepted this cycle
//  req0_a/b     in   WIDTH    requester 0 operands
//  req0_op      in   OP_W     requester 0 opcode
//  req1_*       -    -        same as req0_*, for requester 1
//  resp0_valid  out  1        result for requester 0 available
//  resp0_ready  in   1        requester 0 takes result
//  resp1_valid / resp1_ready  same as resp0_*, for requester 1
//  resp_y       out  WIDTH    captured result; shared by both response channels
//  resp_flags   out  4        captured {c,n,z,v}
//  alu_a/alu_b  out  WIDTH    registered operands to ALU
//  alu_op       out  OP_W     registered opcode to ALU
//  alu_y        in   WIDTH    ALU result (combinational from alu_a/b/op)
//  alu_c/n/z/v  in   1        ALU flags
//  busy         out  1        high whenever state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. The only other transition is reset to IDLE.
//  - IDLE: grant is combinational from valids.
//      - only one valid: that requester wins.
//      - both valid: the requester that was NOT last_grant wins.
//      - reqN_ready = (state==IDLE) & grantN. At most one ready is high.
//      - Accept on valid&ready: latch a/b/op into alu_*, record owner, set last_grant=owner, load cnt=ALU_LAT-1, go EXEC.
//  - EXEC: alu_* held stable. cnt decrements each cycle.
//      - When cnt==0: capture alu_y into resp_y and {alu_c,alu_n,alu_z,alu_v} into resp_flags; go RESP.
//  - RESP: resp<owner>_valid=1. resp_y and resp_flags are held until resp<owner>_ready.
//      - Handshake cycle: go IDLE.
//      - The next accept is possible in the following cycle, not the same one.
//  - Latency: accept at cycle T gives resp_valid from T+ALU_LAT+1. Minimum issue interval is ALU_LAT+2 cycles.
//  - Requests arriving outside IDLE see ready=0 and must hold (valid/data stable until ready).
//  - The non-owner resp_valid is always 0. The channel is never both-valid.
//  - reset: state=IDLE; last_grant=1, so req0 wins the first tie.
//      - All outputs reset to 0: alu_a, alu_b, alu_op, resp_y, resp_flags, all valids/readies, busy.
//  - Reset mid-EXEC or mid-RESP: the in-flight operation is dropped silently, with no response.
//  - alu_* keep their last value in IDLE (no re-zeroing) to avoid ALU toggling.
// CONFIGURATION
//  ALU4_SHARE_PERF_EN defined:
//    - Adds outputs perf_cnt0 and perf_cnt1 (8 bits each).
//    - Counts completed response handshakes per requester.
//    - Saturates at 8'hFF; cleared by reset.
//  ALU4_SHARE_PERF_EN undefined:
//    - Ports and counters are absent.
//    - All other behaviour is identical.
// TESTING
//  1. Single op: reset, req0 a=4'h3 b=4'h5 op=ADD, resp0_ready=1.
//     -> req0_ready at T, resp0_valid at T+2, resp_y=4'h8, flags c=0,n=1,z=0,v=1.
//  2. Tie: req0 and req1 both valid from reset.
//     -> req0 served first, then req1. Repeat: req0/req1 alternate strictly.
//  3. Backpressure: resp1_ready=0 for 5 cycles.
//     -> resp1_valid and resp_y stable; req0_ready stays 0 until the handshake.
//  4. Reset asserted in EXEC.
//     -> next cycle busy=0, all valids 0, no response emitted; a following req1 is served normally.
//  5. ALU_LAT=3: accept at T.
//     -> alu_* stable T+1..T+3, resp_valid at T+4; capture matches alu_y at T+3.
//  6. PERF_EN: 300 req0 ops.
//     -> perf_cnt0=8'hFF, perf_cnt1=0.

Source files
------------

// File: rtl/alu4_share_ctrl.sv
// alu4_share_ctrl: round-robin controller time-sharing one 4-bit ALU between two requesters.
// Define ALU4_SHARE_PERF_EN to add saturating per-requester response counters (perf_cnt0/1).
module alu4_share_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic [3:0]       resp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    output logic             busy
`ifdef ALU4_SHARE_PERF_EN
    ,
    output logic [7:0]       perf_cnt0,
    output logic [7:0]       perf_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [1:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, resp_y_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [3:0]       resp_flags_q;
    logic             resp0_valid_q, resp1_valid_q, busy_q;

    logic grant0, grant1, accept0, accept1, resp_hs;

    // On a tie the requester that did not win last time gets the ALU.
    assign grant0  = req0_valid & (~req1_valid | last_grant_q);
    assign grant1  = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
    assign req1_ready = (state_q == IDLE) & grant1 & ~reset;
    assign accept0    = req0_ready & req0_valid;
    assign accept1    = req1_ready & req1_valid;
    assign resp_hs    = (state_q == RESP) &
                        ((resp0_valid_q & resp0_ready) | (resp1_valid_q & resp1_ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            resp_y_q      <= '0;
            resp_flags_q  <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept0 | accept1) begin
                        alu_a_q      <= accept1 ? req1_a  : req0_a;
                        alu_b_q      <= accept1 ? req1_b  : req0_b;
                        alu_op_q     <= accept1 ? req1_op : req0_op;
                        owner_q      <= accept1;
                        last_grant_q <= accept1;
                        cnt_q        <= 2'(ALU_LAT - 1);
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        resp_y_q      <= alu_y;
                        resp_flags_q  <= {alu_c, alu_n, alu_z, alu_v};
                        resp0_valid_q <= ~owner_q;
                        resp1_valid_q <= owner_q;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_y      = resp_y_q;
    assign resp_flags  = resp_flags_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign busy        = busy_q;

`ifdef ALU4_SHARE_PERF_EN
    logic [7:0] perf0_q, perf1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else if (resp_hs) begin
            if (!owner_q && perf0_q != 8'hFF) perf0_q <= perf0_q + 8'd1;
            if (owner_q && perf1_q != 8'hFF)  perf1_q <= perf1_q + 8'd1;
        end
    end

    assign perf_cnt0 = perf0_q;
    assign perf_cnt1 = perf1_q;
`endif

endmodule
